load_store_unit: RTL and testbench
==================================

# load_store_unit

Core-side initiator for the word-addressed data memory. It takes one load or store request at a time from the execute stage and converts the byte address to a word index. It rejects misaligned or out-of-range addresses and drives the memory's address, write-data and write-enable lines. It returns a single-cycle response carrying the load data or an error flag, and tolerates a configurable memory read latency so the same unit works with combinational or registered block-RAM reads.

## Interface
Parameters:
- `ADDR_W`, 12: word-index width; memory holds 2^ADDR_W 32-bit words.
- `RD_LAT`, 0: cycles between a stable `mem_a` and valid `mem_rd`; legal values are 0..3.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  a request is present.
- `req_ready`  out  1  the unit can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  the request was rejected; qualified by `resp_valid`.
- `mem_a`  out  32  word index, zero-extended from ADDR_W bits.
- `mem_wd`  out  32  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_rd`  in  32  memory read data.

## Operation
- States: IDLE, ACCESS, RESP.
- `req_ready` = (state == IDLE).
- A request is accepted on any edge where `req_valid & req_ready` is true. At that edge the unit latches `req_we`, `req_addr` and `req_wdata`.
- Address check is done on the latched address:
  - misaligned when `addr[1:0] != 0`;
  - out of range when `addr[31:ADDR_W+2] != 0`.
- Error path: IDLE -> RESP directly. No memory access occurs, `mem_we` stays 0, and the response is `resp_err`=1, `resp_rdata`=0.
- Store path: IDLE -> ACCESS for exactly 1 cycle, then RESP.
  - During ACCESS: `mem_a` = `addr[ADDR_W+1:2]`, `mem_wd` = store data, `mem_we` = 1.
  - Response: `resp_err`=0, `resp_rdata`=0.
- Load path: IDLE -> ACCESS for 1+RD_LAT cycles, then RESP.
  - `mem_a` is held constant throughout ACCESS and `mem_we` stays 0.
  - `mem_rd` is sampled at the edge that ends the last ACCESS cycle.
  - Response: `resp_rdata` = the sampled word, `resp_err`=0.
- ACCESS cycles are counted by a counter wide enough for RD_LAT; it is cleared on entry to ACCESS.
- RESP lasts exactly 1 cycle with `resp_valid`=1, then the unit returns to IDLE.
- Responses have no backpressure; the consumer must take the pulse.
- Outside ACCESS:
  - `mem_we` = 0;
  - `mem_a` and `mem_wd` hold their last driven values, which are don't-care to the memory.
- `req_*` inputs are ignored outside IDLE, and the latched request is unaffected by input changes after acceptance.

## Timing
- Accept edge is at the end of cycle T.
- Response cycle, measured from T:
  - error: `resp_valid` in cycle T+1;
  - store: `mem_we` high in cycle T+1, `resp_valid` in cycle T+2;
  - load: ACCESS spans cycles T+1 .. T+1+RD_LAT, `resp_valid` in cycle T+2+RD_LAT.
- Throughput: the next accept is possible in the cycle after RESP. Back-to-back stores therefore run at one per 3 cycles.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0, counter 0.
  - `req_valid` is ignored while `rst` is high.
- Reset mid-operation:
  - all state clears asynchronously;
  - `mem_we` drops immediately, so a store is committed only if its ACCESS edge preceded the reset;
  - the pending request produces no response.
- `resp_rdata` and `resp_err` hold their values after RESP until the next response. Only `resp_valid` qualifies them.

## Structure
- Package `lsu_pkg` holds:
  - `lsu_state_t` enum (IDLE, ACCESS, RESP);
  - the default `ADDR_W` constant, shared with the data memory depth;
  - the `RD_LAT` maximum (3).
- One sub-module is natural: `lsu_addr_check`, combinational. It takes the byte address and ADDR_W and returns the word index, `misaligned` and `out_of_range`.
- All outputs are registered or decoded from state only; there is no combinational path from `req_*` to `mem_*`.

## Test plan
- Store then load, RD_LAT=0:
  - stimulus: store 0xDEADBEEF to 0x10, then load from 0x10;
  - store: `mem_we` for one cycle with `mem_a`=4, `resp_valid` at T+2;
  - load: `resp_rdata`=0xDEADBEEF at T+2, `resp_err`=0.
- RD_LAT=2 with a bench memory delaying `mem_rd` by 2 cycles:
  - stimulus: load from 0x20;
  - response: `mem_a`=8 held for 3 cycles, correct word returned at T+4.
- Misaligned load at 0x13 and store at 0x2:
  - response: `resp_err`=1 at T+1, `resp_rdata`=0, `mem_we` never asserted.
- Out of range, ADDR_W=12:
  - stimulus: store to 0x4000;
  - response: `resp_err`=1, no write. The highest legal address 0x3FFC is written correctly.
- `req_valid` held high continuously with alternating store/load:
  - `req_ready` is low in ACCESS and RESP;
  - each request is accepted exactly once;
  - input changes during ACCESS are ignored.
- `rst` pulsed during load ACCESS:
  - `resp_valid` never asserts for that load;
  - `req_ready`=1 immediately;
  - a following load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its data memory.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } lsu_state_t;

   // Word-index width, also the depth exponent of the data memory.
   localparam int LSU_ADDR_W     = 12;
   localparam int LSU_RD_LAT_MAX = 3;
   localparam int LSU_CNT_W      = 2;

endpackage

// File: rtl/lsu_addr_check.sv
// Byte-address decode: word index plus misalignment and range flags.
module lsu_addr_check
   import lsu_pkg::*;
#(
   parameter int ADDR_W = LSU_ADDR_W
) (
   input  logic [31:0]       addr,
   output logic [ADDR_W-1:0] word_idx,
   output logic              misaligned,
   output logic              out_of_range
);

   assign word_idx     = addr[ADDR_W+1:2];
   assign misaligned   = (addr[1:0] != 2'b00);
   assign out_of_range = ((addr >> (ADDR_W + 2)) != 32'd0);

endmodule

// File: rtl/load_store_unit.sv
// One-at-a-time load/store initiator for a word-addressed memory with
// configurable read latency.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = LSU_ADDR_W,
   parameter int RD_LAT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   localparam logic [LSU_CNT_W-1:0] LAST_CNT = LSU_CNT_W'(RD_LAT);

   lsu_state_t           state_q, state_d;
   logic [LSU_CNT_W-1:0] cnt_q, cnt_d;
   logic                 we_q, we_d;
   logic [31:0]          mem_a_q, mem_a_d;
   logic [31:0]          mem_wd_q, mem_wd_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 err_q, err_d;

   logic [ADDR_W-1:0]    word_idx;
   logic                 misaligned;
   logic                 out_of_range;

   lsu_addr_check #(.ADDR_W(ADDR_W)) u_addr_check (
      .addr         (req_addr),
      .word_idx     (word_idx),
      .misaligned   (misaligned),
      .out_of_range (out_of_range)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      mem_a_d  = mem_a_q;
      mem_wd_d = mem_wd_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d = req_we;
               if (misaligned || out_of_range) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = ACCESS;
                  cnt_d   = '0;
                  mem_a_d = 32'(word_idx);
                  if (req_we) mem_wd_d = req_wdata;
               end
            end
         end
         ACCESS: begin
            // Stores need one cycle; loads wait out the memory read latency.
            if (we_q || (cnt_q == LAST_CNT)) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdata_d = we_q ? '0 : mem_rd;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         mem_a_q  <= '0;
         mem_wd_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         mem_a_q  <= mem_a_d;
         mem_wd_q <= mem_wd_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_a      = mem_a_q;
   assign mem_wd     = mem_wd_q;
   assign mem_we     = (state_q == ACCESS) && we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one instance with RD_LAT=0, one with RD_LAT=2,
// each with its own memory, schedule model and per-cycle checker.
module tb_load_store_unit;

   localparam int AW = 12;
   localparam int NW = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid [2];
   logic        req_we    [2];
   logic        req_ready [2];
   logic        resp_valid[2];
   logic        resp_err  [2];
   logic        mem_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [31:0] resp_rdata[2];
   logic [31:0] mem_a     [2];
   logic [31:0] mem_wd    [2];
   logic [31:0] mem_rd    [2];

   logic [31:0] mem  [2][NW];
   logic [31:0] refm [2][NW];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc %0d: got %h want %h", nm, g, cyc, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = 2 * g;

      load_store_unit #(.ADDR_W(AW), .RD_LAT(LAT)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_we     (req_we[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .resp_valid (resp_valid[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_err   (resp_err[g]),
         .mem_a      (mem_a[g]),
         .mem_wd     (mem_wd[g]),
         .mem_we     (mem_we[g]),
         .mem_rd     (mem_rd[g])
      );

      if (LAT == 0) begin : g_comb
         assign mem_rd[g] = mem[g][mem_a[g][AW-1:0]];
      end else begin : g_pipe
         logic [31:0] p1, p2;
         always @(posedge clk) begin
            p1 <= mem[g][mem_a[g][AW-1:0]];
            p2 <= p1;
         end
         assign mem_rd[g] = p2;
      end

      always @(posedge clk) if (mem_we[g]) mem[g][mem_a[g][AW-1:0]] <= mem_wd[g];

      // Schedule model: on each accept, work out the cycle of every visible event.
      int          rdy_cyc  = 0;
      int          resp_cyc = -1;
      int          we_cyc   = -1;
      int          acc_s    = 1;
      int          acc_e    = 0;
      int          lat;
      logic        bad;
      logic [31:0] e_idx = 0, e_wd = 0, prv_rd = 0, nxt_rd = 0;
      logic        prv_err = 0, nxt_err = 0;

      always @(posedge clk or posedge rst) begin
         if (rst) begin
            rdy_cyc = 0; resp_cyc = -1; we_cyc = -1; acc_s = 1; acc_e = 0;
            prv_rd = 0; nxt_rd = 0; prv_err = 0; nxt_err = 0;
         end else begin
            if (cyc == we_cyc) refm[g][e_idx[AW-1:0]] = e_wd;
            if (req_valid[g] && cyc >= rdy_cyc) begin
               bad = (req_addr[g][1:0] != 2'b00) || (req_addr[g] >= 32'(4 * NW));
               lat = bad ? 1 : (req_we[g] ? 2 : 2 + LAT);
               prv_rd  = nxt_rd;
               prv_err = nxt_err;
               nxt_err = bad;
               nxt_rd  = 0;
               if (!bad && !req_we[g]) nxt_rd = refm[g][req_addr[g] / 4];
               resp_cyc = cyc + lat;
               rdy_cyc  = cyc + lat + 1;
               e_idx    = req_addr[g] / 4;
               e_wd     = req_wdata[g];
               we_cyc   = (!bad && req_we[g]) ? cyc + 1 : -1;
               if (!bad) begin
                  acc_s = cyc + 1;
                  acc_e = cyc + 1 + (req_we[g] ? 0 : LAT);
               end else begin
                  acc_s = 1;
                  acc_e = 0;
               end
            end
         end
      end

      always @(negedge clk) begin
         if (cyc >= 1) begin
            chk("req_ready", g, req_ready[g], cyc >= rdy_cyc);
            chk("resp_valid", g, resp_valid[g], cyc == resp_cyc);
            chk("resp_rdata", g, resp_rdata[g], (cyc >= resp_cyc) ? nxt_rd : prv_rd);
            chk("resp_err", g, resp_err[g], (cyc >= resp_cyc) ? nxt_err : prv_err);
            chk("mem_we", g, mem_we[g], cyc == we_cyc);
            if (cyc >= acc_s && cyc <= acc_e) begin
               chk("mem_a", g, mem_a[g], e_idx);
               if (cyc == we_cyc) chk("mem_wd", g, mem_wd[g], e_wd);
            end
         end
      end
   end

   task automatic issue(input int g, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input bit keep);
      bit acc;
      acc = 1'b0;
      req_valid[g] = 1'b1;
      req_we[g]    = we;
      req_addr[g]  = addr;
      req_wdata[g] = wd;
      for (int k = 0; k < 20 && !acc; k++) begin
         @(negedge clk);
         acc = req_ready[g];
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout dut%0d: got no accept, want accept within 20 cycles", g);
      end
      if (!keep) req_valid[g] = 1'b0;
   endtask

   initial begin
      for (int g = 0; g < 2; g++) begin
         req_valid[g] = 1'b0;
         req_we[g]    = 1'b0;
         req_addr[g]  = '0;
         req_wdata[g] = '0;
         for (int i = 0; i < NW; i++) begin
            mem[g][i]  <= 32'hC0DE_0000 | 32'(i);
            refm[g][i]  = 32'hC0DE_0000 | 32'(i);
         end
      end
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("rst_ready", g, req_ready[g], 1);
         chk("rst_valid", g, resp_valid[g], 0);
         chk("rst_err", g, resp_err[g], 0);
         chk("rst_rdata", g, resp_rdata[g], 0);
         chk("rst_we", g, mem_we[g], 0);
         chk("rst_mem_a", g, mem_a[g], 0);
         chk("rst_mem_wd", g, mem_wd[g], 0);
      end
      @(posedge clk); #1 rst = 1'b0;

      // Store then load, combinational memory.
      issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      chk("lit_st_we", 0, mem_we[0], 1);
      chk("lit_st_a", 0, mem_a[0], 32'd4);
      chk("lit_st_wd", 0, mem_wd[0], 32'hDEAD_BEEF);
      @(negedge clk);
      chk("lit_st_resp", 0, resp_valid[0], 1);
      chk("lit_st_mem", 0, mem[0][4], 32'hDEAD_BEEF);
      @(posedge clk); #1;
      issue(0, 1'b0, 32'h10, 32'h0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("lit_ld_resp", 0, resp_valid[0], 1);
      chk("lit_ld_rdata", 0, resp_rdata[0], 32'hDEAD_BEEF);
      chk("lit_ld_err", 0, resp_err[0], 0);
      @(posedge clk); #1;

      // Misaligned load and store.
      issue(0, 1'b0, 32'h13, 32'h0, 1'b0);
      @(negedge clk);
      chk("lit_mis_ld_v", 0, resp_valid[0], 1);
      chk("lit_mis_ld_err", 0, resp_err[0], 1);
      chk("lit_mis_ld_rd", 0, resp_rdata[0], 0);
      @(posedge clk); #1;
      issue(0, 1'b1, 32'h2, 32'h5555_5555, 1'b0);
      @(negedge clk);
      chk("lit_mis_st_err", 0, resp_err[0], 1);
      chk("lit_mis_st_mem", 0, mem[0][0], 32'hC0DE_0000);
      @(posedge clk); #1;

      // Range limit: first illegal and last legal address.
      issue(0, 1'b1, 32'h4000, 32'h0000_0BAD, 1'b0);
      @(negedge clk);
      chk("lit_oor_err", 0, resp_err[0], 1);
      chk("lit_oor_mem", 0, mem[0][0], 32'hC0DE_0000);
      @(posedge clk); #1;
      issue(0, 1'b1, 32'h3FFC, 32'h1234_5678, 1'b0);
      issue(0, 1'b0, 32'h3FFC, 32'h0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("lit_top_rdata", 0, resp_rdata[0], 32'h1234_5678);
      chk("lit_top_mem", 0, mem[0][NW-1], 32'h1234_5678);
      @(posedge clk); #1;

      // req_valid held high, alternating store/load; next request shows during ACCESS.
      issue(0, 1'b1, 32'h100, 32'hA0A0_0001, 1'b1);
      issue(0, 1'b0, 32'h100, 32'hFFFF_FFFF, 1'b1);
      issue(0, 1'b1, 32'h104, 32'hA0A0_0002, 1'b1);
      issue(0, 1'b0, 32'h104, 32'hFFFF_FFFF, 1'b1);
      issue(0, 1'b1, 32'h108, 32'hA0A0_0003, 1'b1);
      issue(0, 1'b0, 32'h108, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("lit_b2b_rdata", 0, resp_rdata[0], 32'hA0A0_0003);
      repeat (3) @(posedge clk);
      #1;

      // Two-cycle read latency.
      issue(1, 1'b0, 32'h20, 32'h0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("lit_lat_a", 1, mem_a[1], 32'd8);
         chk("lit_lat_nv", 1, resp_valid[1], 0);
      end
      @(negedge clk);
      chk("lit_lat_v", 1, resp_valid[1], 1);
      chk("lit_lat_rd", 1, resp_rdata[1], 32'hC0DE_0008);
      @(posedge clk); #1;
      issue(1, 1'b1, 32'h24, 32'h600D_F00D, 1'b0);
      issue(1, 1'b0, 32'h24, 32'h0, 1'b0);
      repeat (4) @(negedge clk);
      chk("lit_lat_st_ld", 1, resp_rdata[1], 32'h600D_F00D);
      @(posedge clk); #1;

      // Reset in the middle of a slow load.
      issue(1, 1'b0, 32'h28, 32'h0, 1'b0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("lit_rst_ready", 1, req_ready[1], 1);
      chk("lit_rst_nv", 1, resp_valid[1], 0);
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("lit_rst_quiet", 1, resp_valid[1], 0);
      end
      @(posedge clk); #1;
      issue(1, 1'b0, 32'h28, 32'h0, 1'b0);
      repeat (3) @(negedge clk);
      @(negedge clk);
      chk("lit_post_rst_v", 1, resp_valid[1], 1);
      chk("lit_post_rst_rd", 1, resp_rdata[1], 32'hC0DE_000A);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
